conv_result_writer: RTL
=======================

# conv_result_writer

Sink end of the 3×3 window stream. Takes the per-cycle result pixel and stall flag produced behind the window collector and convolution datapath. Discards stalled (invalid-window) samples and writes valid results as a compacted (IMAGE_WIDTH-2)×(IMAGE_HEIGHT-2) frame into feature-map memory through a ready/valid write port. A small FIFO absorbs memory back-pressure, because the upstream pixel stream cannot be stalled.

## Interface
- IMAGE_WIDTH, 256, input frame width in pixels
- IMAGE_HEIGHT, 256, input frame height in pixels
- ADDR_WIDTH, 16, memory address width; must hold BASE_ADDR + frame pixel count − 1
- BASE_ADDR, 0, address of the first output pixel
- FIFO_DEPTH, 8, entries of {address, data}; power of two, ≥2
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse; arms a frame capture when idle
- pix_in  in  8  result pixel, sampled every cycle
- stall_in  in  1  1 = pix_in is not a valid window result; aligned with pix_in
- mem_we  out  1  write request valid
- mem_addr  out  ADDR_WIDTH  write address
- mem_wdata  out  8  write data
- mem_ready  in  1  memory accepts the write this cycle when mem_we=1
- busy  out  1  high in RUN and DRAIN
- frame_done  out  1  one-cycle pulse when the final write is accepted
- overflow  out  1  sticky; FIFO was full when a valid sample arrived

## Operation
- N = (IMAGE_WIDTH−2)·(IMAGE_HEIGHT−2) samples per frame. Internal sample index idx counts 0..N−1.
- FSM states:
  - IDLE → RUN on start.
  - RUN → DRAIN on the cycle the N-th sample is counted.
  - DRAIN → DONE when the FIFO is empty and no write is pending.
  - DONE → IDLE unconditionally after 1 cycle; frame_done=1 in DONE.
- start is ignored outside IDLE.
- RUN: the first sample counted is the one sampled on the cycle after start is seen.
  - Each cycle with stall_in=0 counts one sample: push {BASE_ADDR+idx, pix_in}, then idx+1.
  - Samples with stall_in=1 are dropped and do not advance idx.
- FIFO full with a valid sample:
  - The sample is dropped and overflow is set.
  - idx still advances, so later addresses stay geometrically correct.
  - The dropped address is never written.
- A push and a pop in the same cycle while full is legal only if the pop frees the slot this cycle. Push is permitted when count<FIFO_DEPTH or a pop occurs.
- Output stage holds one registered entry:
  - mem_we/mem_addr/mem_wdata stay stable while mem_we=1 and mem_ready=0.
  - The transfer occurs on a cycle with mem_we=1 and mem_ready=1.
  - The next FIFO head loads in the same cycle, giving back-to-back writes.
- Samples arriving in IDLE, DRAIN and DONE are ignored.
- overflow clears only on rst or on start.
- Arithmetic: addresses are unsigned, ADDR_WIDTH bits. idx width is clog2(N+1) bits. No wrap within a frame.

## Timing
- Reset (rst=1 at an edge): state IDLE, idx=0, FIFO empty, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, frame_done=0, overflow=0.
- Reset mid-frame discards FIFO contents and any pending write with no partial handshake completion. Memory may already hold earlier writes.
- Latency: a valid sample at edge t, with an empty FIFO and idle output stage, drives mem_we=1 after edge t+1.
- Throughput: 1 write/cycle with mem_ready held high. The FIFO never fills in that case.
- busy rises the cycle after start is sampled. It falls on entry to DONE.
- frame_done is high for exactly one cycle, the cycle after the last write's handshake.

## Configuration
- Macro CONV_WRITER_ZERO_BORDER_EN.
  - Defined: every RUN sample is counted. Stalled samples are pushed with data 0, so N = IMAGE_WIDTH·IMAGE_HEIGHT and the output frame uses the same addressing as the input frame.
  - Undefined: compacted (W−2)·(H−2) behaviour as described in Operation.

## Test plan
- W=H=6, BASE_ADDR=0x100, mem_ready=1, 36 samples with stall_in high at rows 0–1 and cols 0–1 → 16 writes at 0x100..0x10F in order, data equal to the valid pix_in values, frame_done exactly once, busy low afterwards.
- Same stimulus, mem_ready toggling 1 cycle on / 1 off → all 16 writes in order; addr/data stable while stalled; overflow=0 with FIFO_DEPTH=8.
- mem_ready=0 for 12 cycles during a valid run, FIFO_DEPTH=4 → overflow=1; the dropped addresses are absent from memory; later addresses are correct; frame still completes.
- rst asserted for 1 cycle mid-RUN with 3 FIFO entries pending → next cycle all outputs at reset values; a new start produces a clean frame from BASE_ADDR.
- start pulsed during RUN and DONE → ignored; no index reset; exactly one frame_done.
- CONV_WRITER_ZERO_BORDER_EN defined, W=H=4, mem_ready=1 → 16 writes at BASE_ADDR..+15; stalled positions hold 0; the others hold pix_in.

Source files
------------

// File: rtl/conv_result_writer.sv
`default_nettype none
// ============================================================================
//  Module   : conv_result_writer
//  Purpose  : Compacts the valid 3x3-window result stream into a feature-map
//             frame and writes it through a ready/valid port behind a FIFO.
//             Build option CONV_WRITER_ZERO_BORDER_EN keeps full-frame
//             addressing and writes stalled positions as zero.
//  Revision : 1.0  initial release
// ============================================================================
module conv_result_writer #(
    parameter int IMAGE_WIDTH  = 256,
    parameter int IMAGE_HEIGHT = 256,
    parameter int ADDR_WIDTH   = 16,
    parameter int BASE_ADDR    = 0,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [7:0]            pix_in,
    input  logic                  stall_in,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [7:0]            mem_wdata,
    input  logic                  mem_ready,
    output logic                  busy,
    output logic                  frame_done,
    output logic                  overflow
);

`ifdef CONV_WRITER_ZERO_BORDER_EN
    localparam int c_N = IMAGE_WIDTH * IMAGE_HEIGHT;
`else
    localparam int c_N = (IMAGE_WIDTH - 2) * (IMAGE_HEIGHT - 2);
`endif
    localparam int c_IDX_W = $clog2(c_N + 1);
    localparam int c_PTR_W = $clog2(FIFO_DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;

    localparam logic [ADDR_WIDTH-1:0] c_BASE     = ADDR_WIDTH'(BASE_ADDR);
    localparam logic [c_IDX_W-1:0]    c_LAST_IDX = c_IDX_W'(c_N - 1);
    localparam logic [c_CNT_W-1:0]    c_DEPTH    = c_CNT_W'(FIFO_DEPTH);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_RUN   = 2'd1;
    localparam logic [1:0] c_ST_DRAIN = 2'd2;
    localparam logic [1:0] c_ST_DONE  = 2'd3;

    logic [1:0]            r_state;
    logic [1:0]            w_state_nxt;
    logic [c_IDX_W-1:0]    r_idx;
    logic [ADDR_WIDTH-1:0] r_fifo_addr [FIFO_DEPTH];
    logic [7:0]            r_fifo_data [FIFO_DEPTH];
    logic [c_PTR_W-1:0]    r_wr_ptr;
    logic [c_PTR_W-1:0]    r_rd_ptr;
    logic [c_CNT_W-1:0]    r_count;
    logic                  r_we;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [7:0]            r_wdata;
    logic                  r_ovf;

    logic                  w_sample;
    logic [7:0]            w_sample_data;
    logic [ADDR_WIDTH-1:0] w_sample_addr;
    logic                  w_xfer;
    logic                  w_pop;
    logic                  w_push;
    logic                  w_drop;

    // A counted sample always advances idx, even when the FIFO has no room.
    always_comb begin
        w_sample      = 1'b0;
        w_sample_data = pix_in;
`ifdef CONV_WRITER_ZERO_BORDER_EN
        w_sample      = (r_state == c_ST_RUN);
        if (stall_in) begin
            w_sample_data = 8'd0;
        end
`else
        w_sample      = (r_state == c_ST_RUN) && !stall_in;
`endif
    end

    assign w_sample_addr = c_BASE + ADDR_WIDTH'(r_idx);
    assign w_xfer        = r_we && mem_ready;
    assign w_pop         = (r_count != '0) && (!r_we || w_xfer);
    assign w_push        = w_sample && ((r_count < c_DEPTH) || w_pop);
    assign w_drop        = w_sample && !w_push;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        busy        = 1'b0;
        frame_done  = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                if (start) begin
                    w_state_nxt = c_ST_RUN;
                end
            end
            c_ST_RUN: begin
                busy = 1'b1;
                if (w_sample && (r_idx == c_LAST_IDX)) begin
                    w_state_nxt = c_ST_DRAIN;
                end
            end
            c_ST_DRAIN: begin
                busy = 1'b1;
                // Leave as the final write is accepted so frame_done follows it directly.
                if ((r_count == '0) && (!r_we || w_xfer)) begin
                    w_state_nxt = c_ST_DONE;
                end
            end
            c_ST_DONE: begin
                frame_done  = 1'b1;
                w_state_nxt = c_ST_IDLE;
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx    <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_we     <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_ovf    <= 1'b0;
        end else begin
            if ((r_state == c_ST_IDLE) && start) begin
                r_idx <= '0;
                r_ovf <= 1'b0;
            end else begin
                if (w_sample) begin
                    r_idx <= r_idx + c_IDX_W'(1);
                end
                if (w_drop) begin
                    r_ovf <= 1'b1;
                end
            end

            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end

            // Output register refills from the FIFO head in the handshake cycle.
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
                r_we     <= 1'b1;
                r_addr   <= r_fifo_addr[r_rd_ptr];
                r_wdata  <= r_fifo_data[r_rd_ptr];
            end else if (w_xfer) begin
                r_we <= 1'b0;
            end

            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_addr[r_wr_ptr] <= w_sample_addr;
            r_fifo_data[r_wr_ptr] <= w_sample_data;
        end
    end

    assign mem_we    = r_we;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign overflow  = r_ovf;

endmodule
`default_nettype wire
